// File: rtl/mio_pkg.sv
// Shared definitions for the CPU memory/IO bus responder: IO bank decode
// constants and the transaction FSM encoding.
package mio_pkg;

    localparam logic [3:0] IO_NIB_DEF = 4'hE;

    localparam logic [3:0] IO_OFF_LED = 4'h0;
    localparam logic [3:0] IO_OFF_SW  = 4'h4;
    localparam logic [3:0] IO_OFF_CNT = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mio_state_t;

endpackage

// File: rtl/mio_ram.sv
// Single-port synchronous word RAM. Read data appears the cycle after the
// address is presented. Contents are not reset.
module mio_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] r_mem [0:(1<<AW)-1];

    // Write-first is not needed: writes and reads of one transaction never overlap.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        dout <= r_mem[addr];
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Target side of the CPU memory/IO bus. Accepts one request at a time,
// waits WAIT_CYC cycles, then services it from RAM or the IO bank and
// pulses mio_ready for one cycle.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no transaction; accept cpu_mio and latch the request
//  WAIT    | programmable wait, wait_cnt counts down to 1
//  DONE    | commit write / present read data, mio_ready high
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW   = 10,
    parameter int unsigned WAIT_CYC = 2,
    parameter logic [3:0]  IO_NIB   = IO_NIB_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mio,
    input  logic        mem_w,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_w,
    output logic [31:0] data_r,
    output logic        mio_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    localparam logic [3:0] WAIT_LD = WAIT_CYC[3:0];

    mio_state_t        r_state;
    logic [3:0]        r_wait_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_mio_ready;
    logic [31:0]       r_data_hold;
    logic [15:0]       r_led;
    logic [31:0]       r_cnt;

    logic              w_done;
    logic              w_is_io;
    logic [3:0]        w_io_off;
    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [31:0]       w_ram_dout;
    logic [31:0]       w_rd_mux;
    logic              w_unused_addr;

    assign w_done   = (r_state == ST_DONE);
    assign w_is_io  = (r_addr[31:28] == IO_NIB);
    assign w_io_off = r_addr[3:0];

    // In IDLE the live address feeds the RAM so a zero-wait read has data in DONE.
    assign w_ram_addr = (r_state == ST_IDLE) ? addr_in[RAM_AW+1:2] : r_addr[RAM_AW+1:2];
    assign w_ram_we   = w_done && r_we && !w_is_io;

    // Address bits between the RAM index and the IO nibble alias away.
    assign w_unused_addr = ^r_addr[27:RAM_AW+2];

    mio_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk  (clk),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .din  (r_wdata),
        .dout (w_ram_dout)
    );

    // Transaction FSM: request latch, wait countdown and the ready pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_mio_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mio_ready <= 1'b0;
                    if (cpu_mio) begin
                        r_addr     <= addr_in;
                        r_wdata    <= data_w;
                        r_we       <= mem_w;
                        r_wait_cnt <= WAIT_LD;
                        if (WAIT_LD == 4'd0) begin
                            r_state     <= ST_DONE;
                            r_mio_ready <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        r_state     <= ST_DONE;
                        r_mio_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_mio_ready <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mio_ready <= 1'b0;
                end
            endcase
        end
    end

    // Read source select on the latched address.
    always_comb begin
        w_rd_mux = '0;
        if (!w_is_io) begin
            w_rd_mux = w_ram_dout;
        end else begin
            case (w_io_off)
                IO_OFF_LED: w_rd_mux = {16'h0000, r_led};
                IO_OFF_SW:  w_rd_mux = {16'h0000, sw_in};
                IO_OFF_CNT: w_rd_mux = r_cnt;
                default:    w_rd_mux = '0;
            endcase
        end
    end

    // Read data is live during DONE (synchronous RAM output lands there) and held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_hold <= '0;
        end else if (w_done && !r_we) begin
            r_data_hold <= w_rd_mux;
        end
    end

    // IO register writes; a counter clear overrides that cycle's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led <= '0;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_done && r_we && w_is_io) begin
                if (w_io_off == IO_OFF_LED) begin
                    r_led <= r_wdata[15:0];
                end
                if (w_io_off == IO_OFF_CNT) begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign data_r    = (w_done && !r_we) ? w_rd_mux : r_data_hold;
    assign mio_ready = r_mio_ready;
    assign led_out   = r_led;

endmodule
